stepper_seq_ctrl: RTL and testbench
===================================

# stepper_seq_ctrl

Command-driven sequencer for a 4-coil unipolar stepper (ST35 class, ULN2803 low-side drivers). It accepts a move command (direction, step count, step period) over a valid/ready handshake and generates full-step two-phase-on coil patterns at a programmable rate. It tracks signed position, holds the coils energized for a dwell after each move, then de-energizes them. It sits between the board-level control logic (buttons or a host register file) and the coil output pins A1/A2/B1/B2.

## Interface
- TICK_DIV, 4096: CLK cycles per step-timing tick (≥2).
- STEPS_W, 16: width of the step-count field.
- PER_W, 12: width of the step-period field, in ticks.
- HOLD_TICKS, 1024: dwell in ticks with coils energized after a move ends (≥1).
- POS_W, 16: width of the position counter.
- CLK  in  1  system clock, single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  move command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_dir  in  1  1 = forward (phase index +1), 0 = reverse.
- cmd_steps  in  STEPS_W  number of steps to move.
- cmd_period  in  PER_W  ticks per step; 0 is treated as 1.
- abort  in  1  level; stops a move in progress.
- A1, A2, B1, B2  out  1 each  registered coil drive, 1 = energized.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a move completes or aborts.
- aborted  out  1  valid with done; 1 = the move was cut short.
- position  out  POS_W  signed step position.

## Operation
- Tick: a free-running counter asserts an internal one-cycle tick every TICK_DIV CLK cycles, starting from reset. It is never reset by commands.
- Phase index ph is 2 bits and persists across moves. It is never cleared except by rstn.
- Coil patterns {A1,A2,B1,B2}: ph0=1010, ph1=0110, ph2=0101, ph3=1001. Coils are 0000 whenever the coils are de-energized.
- Forward moves use ph+1, reverse moves use ph−1. Both wrap modulo 4.
- position ±1 per step and wraps modulo 2^POS_W.
- States:
  - IDLE: coils off, cmd_ready=1.
  - RUN: stepping, cmd_ready=0, busy=1.
  - HOLD: coils on at the current ph, cmd_ready=1, dwell counter running.
- IDLE/HOLD, handshake with cmd_steps=0: no motion, done=1 and aborted=0 in the next cycle. State is unchanged. A HOLD dwell restarts.
- IDLE/HOLD, handshake with cmd_steps>0: latch dir and steps, load the period counter with max(cmd_period,1), then go to RUN. Coils energize at the current ph (no step). Coils stay on if already in HOLD.
- RUN, on each tick: if the period counter is 1, take a step (advance ph, update position, decrement remaining) and reload the period. Otherwise decrement the counter.
- RUN, step that makes remaining 0: go to HOLD, dwell counter = HOLD_TICKS, done=1, aborted=0.
- RUN with abort=1: go to HOLD with no further step, done=1, aborted=1. If abort and a final step coincide in the same cycle, the step is taken and aborted=0.
- abort is ignored outside RUN.
- HOLD, on each tick: decrement the dwell counter. At 0, go to IDLE with coils off.
- A command accepted in HOLD cancels the dwell.

## Timing
- Reset values: A1=A2=B1=B2=0, cmd_ready=1, busy=0, done=0, aborted=0, position=0, ph=0, state IDLE.
- Mid-move reset returns everything to these values immediately, asynchronously.
- Handshake: transfer occurs when cmd_valid & cmd_ready are both high at a rising CLK edge. cmd_ready drops in the following cycle.
- Coils show the current pattern one cycle after acceptance from IDLE.
- Step latency: coil outputs and position change one CLK cycle after the tick on which the period counter was 1.
- The first step is taken on the max(period,1)-th tick after acceptance. Later steps are exactly period ticks apart.
- done is asserted in the same cycle that the final coil pattern appears.
- Coils turn off one cycle after the HOLD_TICKS-th tick in HOLD.

## Structure
- Shared defs include stepper_defs.vh holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, HOLD=2'd2;
  - the four coil-pattern constants;
  - the direction constants.
- Sub-module phase_decoder maps (ph, energize) to {A1,A2,B1,B2}. It is combinational, with output registers in the parent.
- The tick prescaler, FSM, period, dwell, step and position counters live in stepper_seq_ctrl.

## Test plan
Sim parameters: TICK_DIV=4, HOLD_TICKS=3.
1. Reset, then cmd fwd steps=4 period=2. Required: coil sequence 1010→0110→0101→1001→1010, steps 8 ticks apart in total, position=4, done with aborted=0, IDLE after 3 ticks and coils 0000.
2. Reverse 2 steps from ph0, period=1. Required: 1001 then 0101, position=−2 (0xFFFE).
3. Abort raised after 2 of 10 steps. Required: no further steps, done=1, aborted=1, position=2, HOLD then IDLE.
4. New command accepted during HOLD. Required: coils never go 0000, no dwell completion, next step after period ticks.
5. cmd_steps=0, then cmd_period=0 with steps=3. Required: done pulse with no coil activity, then steps on every tick.
6. Position at 0x7FFF with a forward step. Required: 0x8000. Also rstn low mid-RUN: all outputs take reset values in the same cycle.

Source files
------------

// File: rtl/stepper_seq_ctrl_pkg.sv
// Shared definitions for the stepper sequencer: FSM states, coil patterns, direction codes.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package stepper_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Full-step two-phase-on patterns, bit order {A1,A2,B1,B2}
    localparam logic [3:0] COIL_PH0 = 4'b1010;
    localparam logic [3:0] COIL_PH1 = 4'b0110;
    localparam logic [3:0] COIL_PH2 = 4'b0101;
    localparam logic [3:0] COIL_PH3 = 4'b1001;
    localparam logic [3:0] COIL_OFF = 4'b0000;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Phase index after one step in the given direction, wrapping modulo 4
    function automatic logic [1:0] ph_next(input logic [1:0] ph, input logic dir);
        logic [1:0] r;
        r = ph;
        if (dir == DIR_FWD) r = ph + 2'd1;
        if (dir == DIR_REV) r = ph - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/stepper_seq_ctrl_phase_decoder.sv
// Maps phase index and energize flag to the {A1,A2,B1,B2} coil pattern.
// Latency: combinational; the parent registers the result.
// Backpressure: none.
module stepper_seq_ctrl_phase_decoder
    import stepper_seq_ctrl_pkg::*;
(
    input  logic [1:0] ph,
    input  logic       energize,
    output logic [3:0] coils
);

    // Pattern lookup; de-energized coils are forced off regardless of phase
    always_comb begin
        coils = COIL_OFF;
        if (energize) begin
            case (ph)
                2'd0:    coils = COIL_PH0;
                2'd1:    coils = COIL_PH1;
                2'd2:    coils = COIL_PH2;
                default: coils = COIL_PH3;
            endcase
        end
    end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Command-driven full-step sequencer for a 4-coil unipolar stepper with position tracking and dwell.
// Latency: coils/position/done change one cycle after the tick that takes a step; pattern shows one cycle after accept.
// Backpressure: cmd_ready is low only while a move is running (RUN); commands are accepted in IDLE and HOLD.
module stepper_seq_ctrl
    import stepper_seq_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 4096,
    parameter int STEPS_W    = 16,
    parameter int PER_W      = 12,
    parameter int HOLD_TICKS = 1024,
    parameter int POS_W      = 16
) (
    input  logic               CLK,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic [PER_W-1:0]   cmd_period,
    input  logic               abort,
    output logic               A1,
    output logic               A2,
    output logic               B1,
    output logic               B2,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [POS_W-1:0]   position
);

    localparam int TCNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DWELL_W = $clog2(HOLD_TICKS + 1);

    state_t             state_q, state_d;
    logic [TCNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [1:0]         ph_q, ph_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [STEPS_W-1:0] rem_q, rem_d;
    logic [PER_W-1:0]   per_rl_q, per_rl_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dir_q, dir_d;
    logic [3:0]         coils_q, coils_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic               tick;
    logic               accept;
    logic               step;
    logic               last_step;
    logic [PER_W-1:0]   cmd_per_eff;

    assign cmd_ready   = (state_q != ST_RUN);
    assign busy        = (state_q == ST_RUN);
    assign accept      = cmd_valid & cmd_ready;
    assign tick        = (tick_cnt_q == TCNT_W'(TICK_DIV - 1));
    assign cmd_per_eff = (cmd_period == '0) ? PER_W'(1) : cmd_period;
    assign last_step   = tick && (per_cnt_q == PER_W'(1)) && (rem_q == STEPS_W'(1));

    // Free-running prescaler; commands never restart it so step timing stays on a fixed grid
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TCNT_W'(1);
    end

    // Next-state: FSM, period/dwell/step counters, phase and position
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        per_rl_d  = per_rl_q;
        per_cnt_d = per_cnt_q;
        dwell_d   = dwell_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        step      = 1'b0;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (cmd_steps == '0) begin
                        // Zero-length move: report completion and, in HOLD, restart the dwell
                        done_d = 1'b1;
                        if (state_q == ST_HOLD) dwell_d = DWELL_W'(HOLD_TICKS);
                    end else begin
                        dir_d     = cmd_dir;
                        rem_d     = cmd_steps;
                        per_rl_d  = cmd_per_eff;
                        per_cnt_d = cmd_per_eff;
                        state_d   = ST_RUN;
                    end
                end else if (state_q == ST_HOLD && tick) begin
                    if (dwell_q <= DWELL_W'(1)) begin
                        dwell_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
            end
            ST_RUN: begin
                // A final step coinciding with abort still completes normally
                if (last_step) begin
                    step    = 1'b1;
                    state_d = ST_HOLD;
                    dwell_d = DWELL_W'(HOLD_TICKS);
                    done_d  = 1'b1;
                end else if (abort) begin
                    state_d   = ST_HOLD;
                    dwell_d   = DWELL_W'(HOLD_TICKS);
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    if (per_cnt_q == PER_W'(1)) begin
                        step      = 1'b1;
                        per_cnt_d = per_rl_q;
                    end else begin
                        per_cnt_d = per_cnt_q - PER_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (step) begin
            ph_d  = ph_next(ph_q, dir_q);
            pos_d = (dir_q == DIR_FWD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            rem_d = rem_q - STEPS_W'(1);
        end
    end

    // Decode from next-state values so the coil register tracks state/phase with one cycle latency
    stepper_seq_ctrl_phase_decoder u_dec (
        .ph       (ph_d),
        .energize (state_d != ST_IDLE),
        .coils    (coils_d)
    );

    // State and output registers
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            ph_q       <= '0;
            pos_q      <= '0;
            rem_q      <= '0;
            per_rl_q   <= PER_W'(1);
            per_cnt_q  <= PER_W'(1);
            dwell_q    <= '0;
            dir_q      <= DIR_FWD;
            coils_q    <= COIL_OFF;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            ph_q       <= ph_d;
            pos_q      <= pos_d;
            rem_q      <= rem_d;
            per_rl_q   <= per_rl_d;
            per_cnt_q  <= per_cnt_d;
            dwell_q    <= dwell_d;
            dir_q      <= dir_d;
            coils_q    <= coils_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign {A1, A2, B1, B2} = coils_q;
    assign done             = done_q;
    assign aborted          = aborted_q;
    assign position         = pos_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Scoreboard bench for stepper_seq_ctrl: expected coil/position/done events queued per command.
// Latency: n/a.
// Backpressure: commands are held until cmd_ready is seen.
module tb_stepper_seq_ctrl;
    import stepper_seq_ctrl_pkg::*;

    localparam int TD = 4;
    localparam int HT = 3;

    logic        CLK = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [11:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        A1, A2, B1, B2, busy, done, aborted;
    logic [15:0] position;

    logic        rstn_w = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready, w_busy, w_done, w_aborted;
    logic [3:0]  w_coils;
    logic [15:0] w_pos;

    always #5 CLK = ~CLK;

    stepper_seq_ctrl #(.TICK_DIV(TD), .STEPS_W(16), .PER_W(12), .HOLD_TICKS(HT), .POS_W(16)) u_dut (
        .CLK(CLK), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .A1(A1), .A2(A2), .B1(B1), .B2(B2), .busy(busy), .done(done), .aborted(aborted),
        .position(position)
    );

    // Separate instance with a faster tick so the 0x7FFF -> 0x8000 crossing fits in the cycle budget
    stepper_seq_ctrl #(.TICK_DIV(2), .STEPS_W(16), .PER_W(12), .HOLD_TICKS(HT), .POS_W(16)) u_wrap (
        .CLK(CLK), .rstn(rstn_w), .cmd_valid(w_valid), .cmd_ready(w_ready), .cmd_dir(DIR_FWD),
        .cmd_steps(16'h8000), .cmd_period(12'd1), .abort(1'b0),
        .A1(w_coils[3]), .A2(w_coils[2]), .B1(w_coils[1]), .B2(w_coils[0]),
        .busy(w_busy), .done(w_done), .aborted(w_aborted), .position(w_pos)
    );

    typedef struct {
        logic [3:0]  coils;
        logic [15:0] pos;
        logic        dn;
        logic        ab;
        int          gap;
    } evt_t;

    evt_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_evt = 0;
    bit          mon_en = 1'b0;
    logic [3:0]  prev_coils = 4'b0;
    logic [15:0] prev_pos = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [15:0] p, input logic d, input logic a, input int g);
        evt_t e;
        e = '{c, p, d, a, g};
        sbq.push_back(e);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Event monitor: any change of coils/position, or a done pulse, is one observed event
    always @(negedge CLK) begin : mon
        logic [3:0] c;
        evt_t e;
        c = {A1, A2, B1, B2};
        if (rstn && mon_en && (c !== prev_coils || position !== prev_pos || done === 1'b1)) begin
            chk("evt_expected", (sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("coils", c, e.coils);
                chk("position", position, e.pos);
                chk("done_aborted", {done, aborted}, {e.dn, e.ab});
                if (e.gap > 0) chk("evt_gap_cycles", cyc - last_evt, e.gap);
            end
            last_evt = cyc;
        end
        prev_coils = c;
        prev_pos   = position;
    end

    task automatic tb_step();
        @(negedge CLK);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tb_step();
            n++;
        end
        chk(tag, sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic send(input logic dir, input logic [15:0] steps, input logic [11:0] per, output int acc);
        int n;
        tb_step();
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = steps;
        cmd_period = per;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tb_step();
            n++;
        end
        tb_step();
        acc = cyc;
        cmd_valid = 1'b0;
        if (steps != 0) chk("ready_drop_busy", {cmd_ready, busy}, 2'b01);
    endtask

    task automatic wait_pos(input logic [15:0] p, input int budget, output int at);
        int n;
        n = 0;
        while (position !== p && n < budget) begin
            tb_step();
            n++;
        end
        at = cyc;
    endtask

    task automatic main_seq();
        int acc, at;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", {A1, A2, B1, B2, cmd_ready, busy, done, aborted, position},
            {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        tb_step();
        rstn = 1'b1;
        mon_en = 1'b1;
        tb_step();
        chk("post_reset", {A1, A2, B1, B2, cmd_ready, busy, position}, {4'b0, 1'b1, 1'b0, 16'h0});

        // Forward 4 steps, period 2
        push(COIL_PH0, 16'd0, 0, 0, 0);
        push(COIL_PH1, 16'd1, 0, 0, 0);
        push(COIL_PH2, 16'd2, 0, 0, 2 * TD);
        push(COIL_PH3, 16'd3, 0, 0, 2 * TD);
        push(COIL_PH0, 16'd4, 1, 0, 2 * TD);
        push(COIL_OFF, 16'd4, 0, 0, HT * TD);
        send(DIR_FWD, 16'd4, 12'd2, acc);
        drain("fwd4_drain", 300);
        chk("fwd4_idle", {cmd_ready, busy}, 2'b10);

        // Reset back to ph0/position 0, then reverse 2 steps at period 1
        tb_step();
        rstn = 1'b0;
        tb_step();
        rstn = 1'b1;
        push(COIL_PH0, 16'h0000, 0, 0, 0);
        push(COIL_PH3, 16'hFFFF, 0, 0, 0);
        push(COIL_PH2, 16'hFFFE, 1, 0, TD);
        push(COIL_OFF, 16'hFFFE, 0, 0, HT * TD);
        send(DIR_REV, 16'd2, 12'd1, acc);
        drain("rev2_drain", 200);

        // Forward 10 steps from ph2, abort after the second
        push(COIL_PH2, 16'hFFFE, 0, 0, 0);
        push(COIL_PH3, 16'hFFFF, 0, 0, 0);
        push(COIL_PH0, 16'h0000, 0, 0, TD);
        send(DIR_FWD, 16'd10, 12'd1, acc);
        drain("abort_pre_drain", 200);
        abort = 1'b1;
        push(COIL_PH0, 16'h0000, 1, 1, 1);
        push(COIL_OFF, 16'h0000, 0, 0, 0);
        drain("abort_drain", 200);
        abort = 1'b0;
        chk("abort_final", {busy, position}, {1'b0, 16'h0});

        // Two steps, then a new command accepted while holding
        push(COIL_PH0, 16'd0, 0, 0, 0);
        push(COIL_PH1, 16'd1, 0, 0, 0);
        push(COIL_PH2, 16'd2, 1, 0, TD);
        send(DIR_FWD, 16'd2, 12'd1, acc);
        drain("hold_first_drain", 200);
        push(COIL_PH3, 16'd3, 1, 0, 0);
        push(COIL_OFF, 16'd3, 0, 0, HT * TD);
        send(DIR_FWD, 16'd1, 12'd2, acc);
        wait_pos(16'd3, 100, at);
        chk("hold_accept_latency", ((at - acc) >= TD + 1) && ((at - acc) <= 2 * TD), 1);
        drain("hold_second_drain", 200);

        // Zero-step command: done only; then period 0 acts as period 1
        push(COIL_OFF, 16'd3, 1, 0, 0);
        send(DIR_FWD, 16'd0, 12'd5, acc);
        drain("zero_steps_drain", 50);
        chk("zero_steps_idle", {cmd_ready, busy}, 2'b10);
        push(COIL_PH3, 16'd3, 0, 0, 0);
        push(COIL_PH0, 16'd4, 0, 0, 0);
        push(COIL_PH1, 16'd5, 0, 0, TD);
        push(COIL_PH2, 16'd6, 1, 0, TD);
        push(COIL_OFF, 16'd6, 0, 0, HT * TD);
        send(DIR_FWD, 16'd3, 12'd0, acc);
        wait_pos(16'd4, 100, at);
        chk("per0_first_latency", ((at - acc) >= 1) && ((at - acc) <= TD), 1);
        drain("per0_drain", 200);

        // Asynchronous reset in the middle of a move
        mon_en = 1'b0;
        send(DIR_FWD, 16'd20, 12'd1, acc);
        repeat (12) tb_step();
        chk("pre_reset_running", {busy, ({A1, A2, B1, B2} != 4'b0), (position != 16'd6)}, 3'b111);
        rstn = 1'b0;
        #1;
        chk("async_reset", {A1, A2, B1, B2, cmd_ready, busy, done, aborted, position},
            {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        tb_step();
        rstn = 1'b1;
    endtask

    task automatic wrap_seq();
        int n;
        tb_step();
        rstn_w = 1'b1;
        tb_step();
        w_valid = 1'b1;
        tb_step();
        w_valid = 1'b0;
        chk("wrap_busy", {w_ready, w_busy}, 2'b01);
        n = 0;
        while (w_pos !== 16'h7FFF && n < 70000) begin
            tb_step();
            n++;
        end
        chk("wrap_reach_7fff", w_pos, 16'h7FFF);
        n = 0;
        while (w_pos === 16'h7FFF && n < 10) begin
            tb_step();
            n++;
        end
        chk("wrap_pos_8000", w_pos, 16'h8000);
        chk("wrap_done", {w_done, w_aborted}, 2'b10);
    endtask

    initial begin
        fork
            main_seq();
            wrap_seq();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
